conv3x3_stream: RTL and testbench
=================================

# conv3x3_stream

Parametrised streaming 3x3 convolution engine, successor to the fixed-width `top_conv` core in the CNN hardware. It accepts one raster-order pixel per handshake and buffers two image lines internally. For every fully covered window it emits one requantised pixel, applying a run-time shift and output mode. Both sides use valid/ready flow control and the block marks frame boundaries, so it can be chained with other CNN stages.

## Interface
- `IMG_W`, default 28: image width in pixels, ≥3.
- `IMG_H`, default 28: image height in lines, ≥3.
- `PIX_W`, default 8: pixel width; input and output pixels are unsigned.
- `COEF_W`, default 16: width of each signed two's-complement coefficient.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `kernel_i`, in, 9*COEF_W: coefficient k(r,c) is at `[(3r+c)*COEF_W +: COEF_W]`; r=0 is the oldest line, c=0 is the oldest column.
- `shift_i`, in, 5: arithmetic right-shift amount applied to the sum.
- `mode_i`, in, 2: 0 clamp, 1 absolute value, 2 offset, 3 same as 0.
- `s_valid_i`, in, 1: input pixel valid.
- `s_ready_o`, out, 1: block can accept an input pixel.
- `s_data_i`, in, PIX_W: input pixel.
- `m_valid_o`, out, 1: output pixel valid.
- `m_ready_i`, in, 1: downstream accepts the output pixel.
- `m_data_o`, out, PIX_W: output pixel.
- `m_last_o`, out, 1: marks the final output pixel of a frame.
- `frame_done_o`, out, 1: one-cycle pulse on the handshake of the last output.
- `busy_o`, out, 1: a frame is in progress.

## Operation
- An input is accepted when `s_valid_i && s_ready_o`. Column counter `col` runs 0..IMG_W-1 and wraps into row counter `row`, which runs 0..IMG_H-1. After (IMG_H-1, IMG_W-1) both wrap to (0,0).
- Two line buffers, each IMG_W deep, plus a 3x3 window register. Every accepted pixel shifts into the window.
- An input accepted at row≥2 and col≥2 produces one output, for the window centred at (row-1, col-1). This gives (IMG_W-2)·(IMG_H-2) outputs per frame. Other positions only fill the buffers.
- `kernel_i`, `shift_i` and `mode_i` are latched on acceptance of pixel (0,0). Changes during a frame are ignored until the next frame.
- Arithmetic:
  - Each product is the pixel zero-extended to PIX_W+1 bits times the signed coefficient.
  - The sum of 9 products is held in ACC_W = PIX_W+COEF_W+5 bits, signed, with no overflow possible.
  - Then y = sum >>> shift, which floors.
- Output modes:
  - Mode 0: clamp y to [0, 2^PIX_W-1].
  - Mode 1: clamp |y| to [0, 2^PIX_W-1].
  - Mode 2: clamp y + 2^(PIX_W-1) to [0, 2^PIX_W-1].
- Pipeline has 4 stages: window, products, sum, saturated output register. Each stage carries a valid bit and a last bit.
- Global enable `en = !m_valid_o || m_ready_i`. All stages advance only when `en` is high, and `s_ready_o = en`.
- `m_last_o` is asserted with the output produced by input (IMG_H-1, IMG_W-1). `frame_done_o` pulses in the cycle in which `m_valid_o && m_ready_i && m_last_o`.
- `busy_o` sets on acceptance of (0,0) and clears after the `frame_done_o` handshake. If (0,0) of the next frame is accepted in that same cycle, `busy_o` stays high.

## Timing
- Reset values: `s_ready_o`=1, `m_valid_o`=0, `m_data_o`=0, `m_last_o`=0, `frame_done_o`=0, `busy_o`=0. Counters, all pipeline valid bits and latched controls reset to 0.
- Latency: with no stall, an input producing output accepted at edge N gives `m_valid_o`=1 after edge N+3.
- Throughput is one pixel per cycle.
- Stall: while `m_valid_o && !m_ready_i`, `m_data_o` and `m_last_o` hold stable, `s_ready_o`=0, and nothing advances.
- Bubbles (`s_valid_i`=0) propagate as invalid stages. No output is duplicated or lost.
- Frame N+1 may begin while frame N results are still in the pipeline. The kernel is latched per frame, and stale line-buffer data is never emitted because of the row≥2 gating.
- Asserting `rst_i` mid-frame discards all in-flight data immediately. The next accepted pixel is (0,0).

## Test plan
- IMG_W=IMG_H=5, identity kernel (k(1,1)=1), shift 0, mode 0, input ramp 0..24 -> outputs 6,7,8,11,12,13,16,17,18. `m_last_o` only with 18. One `frame_done_o` pulse.
- All-ones kernel, all pixels 255: shift 0 -> every output 255 (saturated from 2295). Shift 4 -> every output 143.
- Kernel k(1,1)=-1, constant pixel 10: mode 0 -> 0; mode 1 -> 10; mode 2 -> 118.
- Test 1 with `m_ready_i` held low for 10 cycles mid-frame, then randomised -> identical output sequence. `m_data_o` stable while stalled. `s_ready_o`=0 during the stall.
- Reset asserted after 13 pixels, then a full frame -> output exactly matches test 1, no stale outputs.
- Two back-to-back frames with the kernel switched to all-ones between them -> frame 2 uses the new kernel. Two single-cycle `frame_done_o` pulses. Measured latency is 3 cycles.

Source files
------------

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_stream
//  Description : Streaming 3x3 convolution over a raster-order pixel stream.
//                Two line buffers feed a 3x3 window. Each fully covered
//                window produces one requantised pixel through a 4-stage
//                pipeline: window, products, sum, saturated output.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_stream #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [9*COEF_W-1:0]   kernel_i,
    input  logic [4:0]            shift_i,
    input  logic [1:0]            mode_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [PIX_W-1:0]      s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [PIX_W-1:0]      m_data_o,
    output logic                  m_last_o,
    output logic                  frame_done_o,
    output logic                  busy_o
);

    localparam int c_COL_W  = $clog2(IMG_W);
    localparam int c_ROW_W  = $clog2(IMG_H);
    localparam int c_PROD_W = PIX_W + 1 + COEF_W;
    localparam int c_ACC_W  = PIX_W + COEF_W + 5;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

    localparam logic signed [c_ACC_W:0] c_PIX_MAX = (c_ACC_W+1)'((1 << PIX_W) - 1);
    localparam logic signed [c_ACC_W:0] c_OFFSET  = (c_ACC_W+1)'(1 << (PIX_W - 1));

    // Handshake and position decode
    logic w_en, w_accept, w_first, w_emit, w_last_pix;

    // Raster position of the next accepted pixel
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;

    // Line buffers: lb0 holds row-2, lb1 holds row-1 at the current column
    logic [PIX_W-1:0] r_lb0 [IMG_W];
    logic [PIX_W-1:0] r_lb1 [IMG_W];

    // Stage 1: window, index 3r+c (r=0 oldest line, c=0 oldest column)
    logic [PIX_W-1:0] r_win [9];
    logic             r_v1, r_l1;

    // Per-frame controls latched on pixel (0,0)
    logic [9*COEF_W-1:0] r_kernel;
    logic [4:0]          r_shift;
    logic [1:0]          r_mode;

    // Stage 2: products
    logic signed [c_PROD_W-1:0] r_prod [9];
    logic                       r_v2, r_l2;
    logic [4:0]                 r_shift2;
    logic [1:0]                 r_mode2;

    // Stage 3: sum
    logic signed [c_ACC_W-1:0] w_sum;
    logic signed [c_ACC_W-1:0] r_sum;
    logic                      r_v3, r_l3;
    logic [4:0]                r_shift3;
    logic [1:0]                r_mode3;

    // Stage 4: requantised output
    logic signed [c_ACC_W-1:0] w_y;
    logic signed [c_ACC_W:0]   w_ext, w_t;
    logic [PIX_W-1:0]          w_sat;
    logic                      r_m_valid, r_m_last;
    logic [PIX_W-1:0]          r_m_data;
    logic                      r_busy;

    assign w_en       = !r_m_valid || m_ready_i;
    assign w_accept   = s_valid_i && w_en;
    assign w_first    = (r_row == '0) && (r_col == '0);
    assign w_emit     = (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);
    assign w_last_pix = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

    assign s_ready_o    = w_en;
    assign m_valid_o    = r_m_valid;
    assign m_data_o     = r_m_data;
    assign m_last_o     = r_m_last;
    assign frame_done_o = r_m_valid && m_ready_i && r_m_last;
    assign busy_o       = r_busy;

    // Line buffers, window shift, products and sum (data path, no reset needed)
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[3*r]   <= r_win[3*r+1];
                r_win[3*r+1] <= r_win[3*r+2];
            end
            r_win[2]     <= r_lb0[r_col];
            r_win[5]     <= r_lb1[r_col];
            r_win[8]     <= s_data_i;
            r_lb0[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= s_data_i;
        end
        if (w_en) begin
            for (int i = 0; i < 9; i++) begin
                r_prod[i] <= $signed({{COEF_W{1'b0}}, r_win[i]}) *
                             $signed({{(PIX_W+1){r_kernel[i*COEF_W+COEF_W-1]}},
                                      r_kernel[i*COEF_W +: COEF_W]});
            end
            r_sum <= w_sum;
        end
    end

    // Adder tree over the nine sign-extended products
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) begin
            w_sum = w_sum + $signed({{(c_ACC_W-c_PROD_W){r_prod[i][c_PROD_W-1]}}, r_prod[i]});
        end
    end

    // Floor shift, apply output mode, saturate to the pixel range
    always_comb begin
        w_y   = r_sum >>> r_shift3;
        w_ext = {w_y[c_ACC_W-1], w_y};
        w_t   = w_ext;
        case (r_mode3)
            2'd1:    if (w_y[c_ACC_W-1]) w_t = -w_ext;
            2'd2:    w_t = w_ext + c_OFFSET;
            default: w_t = w_ext;
        endcase
        if (w_t[c_ACC_W])
            w_sat = '0;
        else if (w_t > c_PIX_MAX)
            w_sat = '1;
        else
            w_sat = w_t[PIX_W-1:0];
    end

    // Counters, control latches, stage valid/last bits, output register, busy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_col     <= '0;
            r_row     <= '0;
            r_kernel  <= '0;
            r_shift   <= '0;
            r_mode    <= '0;
            r_v1      <= 1'b0;
            r_l1      <= 1'b0;
            r_v2      <= 1'b0;
            r_l2      <= 1'b0;
            r_shift2  <= '0;
            r_mode2   <= '0;
            r_v3      <= 1'b0;
            r_l3      <= 1'b0;
            r_shift3  <= '0;
            r_mode3   <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_first) begin
                    r_kernel <= kernel_i;
                    r_shift  <= shift_i;
                    r_mode   <= mode_i;
                end
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + c_ROW_ONE;
                end else begin
                    r_col <= r_col + c_COL_ONE;
                end
            end
            // Shift and mode travel with the data so a new frame's controls
            // never touch results of the previous frame still in flight.
            if (w_en) begin
                r_v1      <= w_accept && w_emit;
                r_l1      <= w_accept && w_last_pix;
                r_v2      <= r_v1;
                r_l2      <= r_l1;
                r_shift2  <= r_shift;
                r_mode2   <= r_mode;
                r_v3      <= r_v2;
                r_l3      <= r_l2;
                r_shift3  <= r_shift2;
                r_mode3   <= r_mode2;
                r_m_valid <= r_v3;
                r_m_last  <= r_l3;
                if (r_v3)
                    r_m_data <= w_sat;
            end
            if (w_accept && w_first)
                r_busy <= 1'b1;
            else if (frame_done_o)
                r_busy <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv3x3_stream
//  Description : Self-checking bench for conv3x3_stream on a 5x5 image with
//                a frame-level reference model and directed frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_stream;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int PW = 8;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [9*CW-1:0] kernel = '0;
    logic [4:0]      shift = '0;
    logic [1:0]      mode = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [PW-1:0]   s_data = '0;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [PW-1:0]   m_data;
    logic            m_last;
    logic            frame_done;
    logic            busy;

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .COEF_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .kernel_i(kernel), .shift_i(shift), .mode_i(mode),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .m_last_o(m_last), .frame_done_o(frame_done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fd_count = 0;
    int last_in_cyc = 0;
    bit lat_en = 1'b0;
    int stall_from = -1;
    int stall_len = 0;
    bit rand_rdy = 1'b0;
    int exp_d[$];
    bit exp_l[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int clamp8(input longint v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return int'(v);
    endfunction

    // Reference: every fully covered window of the frame, raster order
    task automatic model_out(input int img[25], input int k[9], input int sh, input int md,
                             output int res[9]);
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                longint s = 0;
                longint y;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += longint'(k[3*i+j]) * longint'(img[(r-2+i)*W + (c-2+j)]);
                y = s >>> sh;
                if (md == 1 && y < 0) y = -y;
                if (md == 2) y = y + 128;
                res[(r-2)*3 + (c-2)] = clamp8(y);
            end
        end
    endtask

    // Downstream ready: optional fixed stall window, otherwise always or random
    always @(posedge clk) begin
        #1;
        if (cyc >= stall_from && cyc < stall_from + stall_len)
            m_ready = 1'b0;
        else if (rand_rdy)
            m_ready = ($urandom_range(0, 3) != 0);
        else
            m_ready = 1'b1;
    end

    // Output monitor: scoreboard, stall stability, frame_done, latency
    bit prev_stall = 1'b0;
    int prev_d = 0;
    int prev_l = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_data_stable", m_data, prev_d);
                chk("stall_last_stable", m_last, prev_l);
                chk("stall_valid_held", m_valid, 1);
            end
            if (m_valid && !m_ready)
                chk("s_ready_low_in_stall", s_ready, 0);
            if (frame_done || (m_valid && m_ready && m_last)) begin
                chk("frame_done_pulse", frame_done, m_valid && m_ready && m_last);
                if (frame_done) fd_count++;
            end
            if (m_valid && m_ready) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_output", m_valid, 0);
                end else begin
                    chk("out_data", m_data, exp_d.pop_front());
                    chk("out_last", m_last, exp_l.pop_front());
                    if (m_last && lat_en)
                        chk("latency", cyc - last_in_cyc, 3);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
        end
    end

    task automatic send_pixel(input int p, input bit gaps);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data = p[PW-1:0];
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0;
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic run_frame(input int img[25], input int k[9], input int sh, input int md,
                             input int npix, input bit gaps, input bit scramble,
                             input int stall_at);
        int res[9];
        for (int i = 0; i < 9; i++) kernel[i*CW +: CW] = k[i][CW-1:0];
        shift = sh[4:0];
        mode = md[1:0];
        if (npix == W*H) begin
            model_out(img, k, sh, md, res);
            for (int i = 0; i < 9; i++) begin
                exp_d.push_back(res[i]);
                exp_l.push_back(i == 8);
            end
        end
        for (int p = 0; p < npix; p++) begin
            send_pixel(img[p], gaps);
            if (p == 0) chk("busy_set", busy, 1);
            if (scramble && p == 5) begin
                kernel = '1;
                shift = 5'd3;
                mode = 2'd1;
            end
            if (p == stall_at) begin
                stall_from = cyc + 1;
                stall_len = 10;
                rand_rdy = 1'b1;
            end
            if (p == W*H-1) last_in_cyc = cyc;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_d.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", exp_d.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int ramp[25], c255[25], c10[25];
        int ident[9], ones[9], neg[9];
        int res[9];
        int lit1[9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        int fd0;
        for (int i = 0; i < 25; i++) begin
            ramp[i] = i;
            c255[i] = 255;
            c10[i] = 10;
        end
        for (int i = 0; i < 9; i++) begin
            ident[i] = (i == 4) ? 1 : 0;
            ones[i] = 1;
            neg[i] = (i == 4) ? -1 : 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Identity kernel on a ramp; pin the model against hand values
        model_out(ramp, ident, 0, 0, res);
        for (int i = 0; i < 9; i++) chk("model_identity", res[i], lit1[i]);
        fd0 = fd_count;
        run_frame(ramp, ident, 0, 0, 25, 1'b0, 1'b0, -1);
        wait_drain();
        chk("t1_frame_done_count", fd_count - fd0, 1);
        chk("t1_busy_clear", busy, 0);

        // All-ones kernel on saturated pixels, shift 0 then shift 4
        model_out(c255, ones, 0, 0, res);
        chk("model_sat_shift0", res[0], 255);
        model_out(c255, ones, 4, 0, res);
        chk("model_sat_shift4", res[8], 143);
        run_frame(c255, ones, 0, 0, 25, 1'b0, 1'b0, -1);
        run_frame(c255, ones, 4, 0, 25, 1'b0, 1'b0, -1);
        wait_drain();

        // Negative centre tap under the three output modes
        model_out(c10, neg, 0, 0, res);
        chk("model_mode0", res[4], 0);
        model_out(c10, neg, 0, 1, res);
        chk("model_mode1", res[4], 10);
        model_out(c10, neg, 0, 2, res);
        chk("model_mode2", res[4], 118);
        run_frame(c10, neg, 0, 0, 25, 1'b0, 1'b0, -1);
        run_frame(c10, neg, 0, 1, 25, 1'b0, 1'b0, -1);
        run_frame(c10, neg, 0, 2, 25, 1'b0, 1'b0, -1);
        wait_drain();

        // Stall for 10 cycles, then random ready and input bubbles;
        // controls changed mid-frame must be ignored
        run_frame(ramp, ident, 0, 0, 25, 1'b1, 1'b1, 15);
        wait_drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset after 13 pixels, then a clean frame
        run_frame(ramp, ident, 0, 0, 13, 1'b0, 1'b0, -1);
        rst = 1'b1;
        exp_d.delete();
        exp_l.delete();
        @(negedge clk);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_s_ready", s_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(ramp, ident, 0, 0, 25, 1'b0, 1'b0, -1);
        wait_drain();

        // Back-to-back frames with a kernel switch; latency measured
        model_out(ramp, ones, 0, 0, res);
        chk("model_ones_first", res[0], 54);
        chk("model_ones_last", res[8], 162);
        fd0 = fd_count;
        lat_en = 1'b1;
        run_frame(ramp, ident, 0, 0, 25, 1'b0, 1'b0, -1);
        run_frame(ramp, ones, 0, 0, 25, 1'b0, 1'b0, -1);
        wait_drain();
        lat_en = 1'b0;
        chk("t6_frame_done_count", fd_count - fd0, 2);
        chk("t6_busy_clear", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
